// File: rtl/ex_fwd_ctrl.sv
// Execute-stage forwarding and load-use stall controller over a 2-deep producer tag pipeline.
// Build option FWD_MW_PATH_EN: operand B takes a non-load M-stage result over the ALU M/W path (select 11).
module ex_fwd_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid_i,
  input  logic [2:0] id_src_idx_i,
  input  logic       id_src_used_i,
  input  logic [2:0] id_dst_idx_i,
  input  logic       id_dst_used_i,
  input  logic       id_wr_en_i,
  input  logic       id_is_load_i,
  input  logic       flush_i,
  output logic [1:0] fu_src_sel_o,
  output logic [1:0] fu_dst_sel_o,
  output logic       stall_o,
  output logic       ex_valid_o
);

  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic       is_load;
    logic [2:0] dst_idx;
  } tag_t;

  localparam logic [1:0] SEL_MUX = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_EM  = 2'b10;
  localparam logic [1:0] SEL_MW  = 2'b11;

`ifdef FWD_MW_PATH_EN
  localparam logic MW_PATH_EN = 1'b1;
`else
  localparam logic MW_PATH_EN = 1'b0;
`endif

  // The W-stage tag is not kept: the register file is write-first, so W never forwards.
  tag_t       e_q, e_d;
  tag_t       m_q;
  logic [1:0] src_sel_q, src_sel_d;
  logic [1:0] dst_sel_q, dst_sel_d;

  logic p1_wr, p2_wr;
  logic src_p1, src_p2, dst_p1, dst_p2;
  logic accept;

  assign p1_wr  = e_q.valid & e_q.wr_en;
  assign p2_wr  = m_q.valid & m_q.wr_en;
  assign src_p1 = id_src_used_i & p1_wr & (e_q.dst_idx == id_src_idx_i);
  assign src_p2 = id_src_used_i & p2_wr & (m_q.dst_idx == id_src_idx_i);
  assign dst_p1 = id_dst_used_i & p1_wr & (e_q.dst_idx == id_dst_idx_i);
  assign dst_p2 = id_dst_used_i & p2_wr & (m_q.dst_idx == id_dst_idx_i);

  assign stall_o = id_valid_i & ~flush_i & e_q.is_load & (src_p1 | dst_p1);
  assign accept  = id_valid_i & ~flush_i & ~stall_o;

  always_comb begin
    e_d       = '0;
    src_sel_d = SEL_MUX;
    dst_sel_d = SEL_MUX;
    if (accept) begin
      e_d.valid   = 1'b1;
      e_d.wr_en   = id_wr_en_i;
      e_d.is_load = id_is_load_i;
      e_d.dst_idx = id_dst_idx_i;
      if (src_p1)      src_sel_d = SEL_EM;
      else if (src_p2) src_sel_d = SEL_WB;
      if (dst_p1)      dst_sel_d = SEL_EM;
      else if (dst_p2) dst_sel_d = (MW_PATH_EN && !m_q.is_load) ? SEL_MW : SEL_WB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q       <= '0;
      m_q       <= '0;
      src_sel_q <= SEL_MUX;
      dst_sel_q <= SEL_MUX;
    end else begin
      e_q       <= e_d;
      m_q       <= e_q;
      src_sel_q <= src_sel_d;
      dst_sel_q <= dst_sel_d;
    end
  end

  assign fu_src_sel_o = src_sel_q;
  assign fu_dst_sel_o = dst_sel_q;
  assign ex_valid_o   = e_q.valid;

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Self-checking bench for ex_fwd_ctrl: directed hazard scenarios then randomized traffic vs. a slot-history model.
module tb_ex_fwd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_src_idx;
  logic       id_src_used;
  logic [2:0] id_dst_idx;
  logic       id_dst_used;
  logic       id_wr_en;
  logic       id_is_load;
  logic       flush;
  logic [1:0] fu_src_sel;
  logic [1:0] fu_dst_sel;
  logic       stall;
  logic       ex_valid;

  int checks   = 0;
  int failures = 0;

  ex_fwd_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid_i   (id_valid),
    .id_src_idx_i (id_src_idx),
    .id_src_used_i(id_src_used),
    .id_dst_idx_i (id_dst_idx),
    .id_dst_used_i(id_dst_used),
    .id_wr_en_i   (id_wr_en),
    .id_is_load_i (id_is_load),
    .flush_i      (flush),
    .fu_src_sel_o (fu_src_sel),
    .fu_dst_sel_o (fu_dst_sel),
    .stall_o      (stall),
    .ex_valid_o   (ex_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef FWD_MW_PATH_EN
  localparam bit MW_EN = 1'b1;
`else
  localparam bit MW_EN = 1'b0;
`endif

  // Reference: the instructions that entered execute, most recent first (bubbles included).
  typedef struct {
    bit v;
    bit wr;
    bit ld;
    int dst;
  } slot_t;
  slot_t hist[$];
  bit    last_stall;

  function automatic int nearest_writer(input int idx);
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].v && hist[i].wr && hist[i].dst == idx) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] s, input logic su,
                      input logic [2:0] d, input logic du, input logic wr,
                      input logic ld, input logic fl);
    int    ds, dd;
    bit    exp_stall, acc;
    logic [1:0] exp_src, exp_dst;
    slot_t ns;
    @(negedge clk);
    id_valid = v; id_src_idx = s; id_src_used = su; id_dst_idx = d;
    id_dst_used = du; id_wr_en = wr; id_is_load = ld; flush = fl;
    #1;
    ds = su ? nearest_writer(int'(s)) : -1;
    dd = du ? nearest_writer(int'(d)) : -1;
    exp_stall = v && !fl && ((ds == 0 && hist[0].ld) || (dd == 0 && hist[0].ld));
    chk("stall", {1'b0, stall}, {1'b0, exp_stall});
    last_stall = exp_stall;
    acc = v && !fl && !exp_stall;
    exp_src = 2'b00;
    exp_dst = 2'b00;
    if (acc) begin
      if (ds == 0) exp_src = 2'b10;
      else if (ds == 1) exp_src = 2'b01;
      if (dd == 0) exp_dst = 2'b10;
      else if (dd == 1) exp_dst = (MW_EN && !hist[1].ld) ? 2'b11 : 2'b01;
    end
    ns.v = acc; ns.wr = acc && wr; ns.ld = acc && ld; ns.dst = acc ? int'(d) : 0;
    hist.push_front(ns);
    if (hist.size() > 2) void'(hist.pop_back());
    @(posedge clk);
    #1;
    chk("ex_valid", {1'b0, ex_valid}, {1'b0, acc});
    chk("src_sel", fu_src_sel, exp_src);
    chk("dst_sel", fu_dst_sel, exp_dst);
  endtask

  initial begin
    logic [2:0] rs, rd;
    logic rv, rsu, rdu, rwr, rld, rfl;
    rst_n = 1'b0;
    id_valid = 0; id_src_idx = 0; id_src_used = 0; id_dst_idx = 0;
    id_dst_used = 0; id_wr_en = 0; id_is_load = 0; flush = 0;
    last_stall = 0;
    #2;
    chk("rst_stall", {1'b0, stall}, 2'b00);
    chk("rst_ex_valid", {1'b0, ex_valid}, 2'b00);
    chk("rst_src", fu_src_sel, 2'b00);
    chk("rst_dst", fu_dst_sel, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD R1 ; ADD R2,R1
    step(1, 0, 0, 1, 0, 1, 0, 0);
    step(1, 1, 1, 2, 0, 1, 0, 0);
    chk("back2back_src", fu_src_sel, 2'b10);

    // ADD R3 ; NOP ; SUB with R3 as operand B
    step(1, 0, 0, 3, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2, 0, 3, 1, 1, 0, 0);
    chk("mw_dst", fu_dst_sel, MW_EN ? 2'b11 : 2'b01);

    // LDD R4 ; use R4 (stall one cycle, then WB forward)
    step(1, 0, 0, 4, 0, 1, 1, 0);
    step(1, 4, 1, 5, 0, 1, 0, 0);
    chk("loaduse_bubble", {1'b0, ex_valid}, 2'b00);
    step(1, 4, 1, 5, 0, 1, 0, 0);
    chk("loaduse_src", fu_src_sel, 2'b01);
    chk("loaduse_nostall", {1'b0, stall}, 2'b00);

    // Two producers of R5 ; consumer takes the nearest
    step(1, 0, 0, 5, 0, 1, 0, 0);
    step(1, 0, 0, 5, 0, 1, 0, 0);
    step(1, 5, 1, 6, 0, 1, 0, 0);
    chk("nearest_src", fu_src_sel, 2'b10);

    // Load-use with flush in the same cycle
    step(1, 0, 0, 6, 0, 1, 1, 0);
    step(1, 6, 1, 7, 0, 1, 0, 1);
    chk("flush_valid", {1'b0, ex_valid}, 2'b00);

    // Reset asserted during a load-use stall
    step(1, 0, 0, 4, 0, 1, 1, 0);
    @(negedge clk);
    id_valid = 1; id_src_idx = 4; id_src_used = 1; id_dst_idx = 1;
    id_dst_used = 0; id_wr_en = 1; id_is_load = 0; flush = 0;
    #1;
    chk("pre_rst_stall", {1'b0, stall}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", {1'b0, stall}, 2'b00);
    chk("midrst_ex_valid", {1'b0, ex_valid}, 2'b00);
    chk("midrst_src", fu_src_sel, 2'b00);
    chk("midrst_dst", fu_dst_sel, 2'b00);
    hist.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4, 1, 4, 1, 1, 0, 0);
    chk("postrst_src", fu_src_sel, 2'b00);
    chk("postrst_valid", {1'b0, ex_valid}, 2'b01);

    // Randomized traffic; a stalled instruction is re-presented unchanged
    rv = 0; rs = 0; rsu = 0; rd = 0; rdu = 0; rwr = 0; rld = 0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        rv  = ($urandom_range(0, 99) < 85);
        rs  = 3'($urandom_range(0, 3));
        rsu = 1'($urandom_range(0, 1));
        rd  = 3'($urandom_range(0, 3));
        rdu = 1'($urandom_range(0, 1));
        rwr = ($urandom_range(0, 99) < 75);
        rld = rwr && ($urandom_range(0, 99) < 35);
      end
      rfl = ($urandom_range(0, 99) < 10);
      step(rv, rs, rsu, rd, rdu, rwr, rld, rfl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_fwd_ctrl.md
EX_FWD_CTRL -- requirements
Module: ex_fwd_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 id_valid  in  1  decode stage holds a real instruction.
REQ-004 id_src_idx  in  3  source register index; id_src_used in 1 marks it read.
REQ-005 id_dst_idx  in  3  destination register index; id_dst_used in 1 marks it read as operand B.
REQ-006 id_wr_en  in  1  decode instruction writes id_dst_idx.
REQ-007 id_is_load  in  1  decode instruction's result comes from memory, not ALU.
REQ-008 flush  in  1  branch taken; discard the decode instruction this cycle.
REQ-009 FU_Src_Sel  out  2  registered operand-A forward select: 00 mux, 01 WB, 10 ALU after E/M.
REQ-010 FU_Dst_Sel  out  2  registered operand-B forward select: 00 mux, 01 WB, 10 ALU after E/M, 11 ALU M/W.
REQ-011 stall  out  1  combinational; freeze fetch/decode and insert an execute bubble.
REQ-012 ex_valid  out  1  registered; execute stage holds a real instruction.

Function
REQ-013 Internal tag pipeline E, M, W: each entry holds {valid, wr_en, is_load, dst_idx[2:0]}.
REQ-014 Each rising edge: W<=M, M<=E; E<=decode tag if id_valid & !stall & !flush, else bubble (all zero).
REQ-015 Producer P1 = E entry (valid & wr_en); producer P2 = M entry (valid & wr_en); W entry needs no forwarding (register file is write-first).
REQ-016 Source match: id_src_used & P1.dst_idx==id_src_idx -> next FU_Src_Sel=10; else P2 match -> 01; else 00.
REQ-017 Dest match: same priority rule on id_dst_idx -> 10 for P1, 01 for P2, else 00 (see REQ-027).
REQ-018 P1 always wins over P2 when both match the same index.
REQ-019 stall = id_valid & !flush & P1.is_load & (source match on P1 | dest match on P1).
REQ-020 Stall lasts exactly one cycle per load-use; next cycle the load is in M, its data arrives via WB, so the consumer gets select 01.
REQ-021 FU_Src_Sel/FU_Dst_Sel/ex_valid load at each edge with the values computed for the instruction entering E; bubble, stall or flush loads 00/00/0.
REQ-022 flush overrides stall in the same cycle: stall=0, bubble inserted, pending forward discarded.
REQ-023 Instructions with id_src_used=0 / id_dst_used=0 never stall or forward on that operand.
REQ-024 Register index 0 is not special; any index matches.

Reset
REQ-025 rst low (async): E, M, W cleared to bubble; FU_Src_Sel=00, FU_Dst_Sel=00, ex_valid=0; stall therefore 0.
REQ-026 Reset asserted mid-stall cancels the stall immediately; after release, first edge accepts the decode instruction with no forwarding.

Configuration
REQ-027 FWD_MW_PATH_EN: defined -> dest match on a non-load P2 selects FU_Dst_Sel=11 (ALU M/W); undefined -> 01; load P2 and source operand always use 01 in both builds.

Verification
REQ-028 ADD R1 then ADD R2,R1 back-to-back -> consumer enters E with FU_Src_Sel=10, no stall.
REQ-029 ADD R3, NOP, SUB R3 as dest -> FU_Dst_Sel=01 undefined, 11 with FWD_MW_PATH_EN.
REQ-030 LDD R4 followed by use of R4 -> stall=1 for one cycle, ex_valid=0 bubble, then consumer in E with sel 01.
REQ-031 P1 and P2 both write R5, consumer reads R5 -> FU_Src_Sel=10 (nearest producer).
REQ-032 Load-use stall with flush=1 same cycle -> stall=0, ex_valid=0 next edge, selects 00.
REQ-033 rst low during stall -> outputs 00/00/0 immediately; after release, independent instruction -> selects 00.
